// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg: shared types for the L1-to-L2 port arbiter.
package l2_arbiter_pkg;
  localparam int LC3B_LINE_WIDTH = 128;
  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_line;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
  typedef enum logic {ARB_I, ARB_D} arb_id_t;
endpackage

// File: rtl/l2_arbiter_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= clr ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the L2 port between I-cache and D-cache miss paths,
// round-robin on conflict, with saturating grant/conflict counters.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16,
  parameter bit D_FIRST    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [15:0]           i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [15:0]           d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [15:0]           l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic                  l2_resp,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  clear_counters,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  i_grant_count,
  output logic [CNT_WIDTH-1:0]  d_grant_count,
  output logic [CNT_WIDTH-1:0]  conflict_count
);
  arb_state_t state;
  arb_id_t    last_served;
  logic       idle, req_i, req_d, conflict, grant_i, grant_d;
  assign idle     = state == IDLE;
  assign req_i    = i_read;
  assign req_d    = d_read | d_write;
  assign conflict = idle & req_i & req_d;
  // On conflict the side that was not served last wins.
  assign grant_d  = idle & req_d & (~req_i | (last_served == ARB_I));
  assign grant_i  = idle & req_i & ~grant_d;
  assign i_resp   = (state == SERVE_I) & l2_resp;
  assign d_resp   = (state == SERVE_D) & l2_resp;
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;
  assign busy     = !idle;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      last_served <= D_FIRST ? ARB_I : ARB_D;
      l2_read     <= 1'b0;
      l2_write    <= 1'b0;
      l2_address  <= '0;
      l2_wdata    <= '0;
    end else
      case (state)
        IDLE:
          if (grant_i) begin
            state       <= SERVE_I;
            last_served <= ARB_I;
            l2_address  <= i_address;
            l2_read     <= 1'b1;
          end else if (grant_d) begin
            state       <= SERVE_D;
            last_served <= ARB_D;
            l2_address  <= d_address;
            l2_read     <= ~d_write;
            l2_write    <= d_write;
            if (d_write) l2_wdata <= d_wdata;
          end
        SERVE_I, SERVE_D:
          if (l2_resp) begin
            state    <= RELEASE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
          end
        default: state <= IDLE;
      endcase
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_i_cnt (
    .clk(clk), .reset(reset), .inc(grant_i), .clr(clear_counters), .count(i_grant_count));
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_d_cnt (
    .clk(clk), .reset(reset), .inc(grant_d), .clr(clear_counters), .count(d_grant_count));
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_c_cnt (
    .clk(clk), .reset(reset), .inc(conflict), .clr(clear_counters), .count(conflict_count));
endmodule
